// File: rtl/rv_pkg.sv
// ============================================================================
// rv_pkg : shared RV32I fetch-side types and constants
// Rev 1.0
// ============================================================================
`default_nettype none

package rv_pkg;

    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HALT  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fq_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// fetch_fifo : synchronous FIFO with extra-bit wrap pointers and flush
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic [63:0]
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  T                         wdata_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output T                         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    T               mem_q [DEPTH];
    logic [AW:0]    wptr_q;
    logic [AW:0]    rptr_q;
    logic           w_push;
    logic           w_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign count_o = wptr_q - rptr_q;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    // A push into a full queue is legal only alongside a pop: the slot being read is reused.
    assign w_push = push_i && (!full_o || pop_i);
    assign w_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else if (flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            assert (!(push_i && full_o && !pop_i));
            if (w_push) wptr_q <= wptr_q + 1'b1;
            if (w_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !flush_i) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// instr_fetch_unit : RV32I instruction fetch with credit-limited issue and redirect flush
// Rev 1.0
// ============================================================================
`default_nettype none

module instr_fetch_unit
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] iaddr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] idata,
    output logic [31:0] pc,
    output logic        misalign_err
);

    localparam int CW = $clog2(FQ_DEPTH) + 1;

    fetch_state_t    state_q, state_d;
    logic [31:0]     fpc_q, fpc_d;
    logic [31:0]     rpc_q, rpc_d;
    logic [CW-1:0]   in_flight_q, in_flight_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic            misalign_q;
    logic [31:0]     last_pc_q;

    logic [CW-1:0]   w_count;
    logic            w_full;
    logic            w_empty;
    fq_entry_t       w_head;
    fq_entry_t       w_wdata;
    logic            w_push;
    logic            w_pop;
    logic            w_grant;
    logic            w_redir_ok;
    logic [CW:0]     w_credits_used;

    assign w_redir_ok     = redirect_valid && (redirect_pc[1:0] == 2'b00);
    assign w_credits_used = {1'b0, w_count} + {1'b0, in_flight_q};

    assign imem_req = !reset && (state_q == FETCH) && (w_credits_used < (CW+1)'(FQ_DEPTH));
    assign iaddr    = fpc_q;
    assign w_grant  = imem_req && imem_gnt;

    assign id_valid     = !w_empty;
    assign idata        = w_empty ? RV_NOP : w_head.instr;
    assign pc           = w_empty ? last_pc_q : w_head.pc;
    assign misalign_err = misalign_q;
    assign w_pop        = id_valid && id_ready;
    assign w_wdata      = '{instr: imem_rdata, pc: rpc_q};

    always_comb begin
        state_d     = state_q;
        fpc_d       = fpc_q;
        rpc_d       = rpc_q;
        drop_d      = drop_q;
        w_push      = 1'b0;
        in_flight_d = in_flight_q + CW'(w_grant) - CW'(imem_rvalid);

        // rpc_q tracks the address of the oldest live request; stale words carry no PC.
        if (imem_rvalid && (drop_q != '0)) begin
            drop_d = drop_q - 1'b1;
        end else if (imem_rvalid) begin
            w_push = !redirect_valid;
            rpc_d  = rpc_q + 32'd4;
        end

        if (w_grant) fpc_d = fpc_q + 32'd4;

        // Everything still outstanding after this cycle belongs to the old stream.
        if (redirect_valid) begin
            drop_d = in_flight_d;
            if (w_redir_ok) begin
                state_d = FETCH;
                fpc_d   = redirect_pc;
                rpc_d   = redirect_pc;
            end else begin
                state_d = HALT;
                fpc_d   = fpc_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FETCH;
            fpc_q       <= RESET_PC;
            rpc_q       <= RESET_PC;
            in_flight_q <= '0;
            drop_q      <= '0;
            misalign_q  <= 1'b0;
            last_pc_q   <= RESET_PC;
        end else begin
            state_q     <= state_d;
            fpc_q       <= fpc_d;
            rpc_q       <= rpc_d;
            in_flight_q <= in_flight_d;
            drop_q      <= drop_d;
            misalign_q  <= redirect_valid && !w_redir_ok;
            if (!w_empty) last_pc_q <= w_head.pc;
        end
    end

    fetch_fifo #(
        .DEPTH (FQ_DEPTH),
        .T     (fq_entry_t)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (w_push),
        .wdata_i (w_wdata),
        .pop_i   (w_pop),
        .flush_i (redirect_valid),
        .rdata_o (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count)
    );

endmodule

`default_nettype wire
